// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared request-bus command, burst-length and target FSM types
package bus_pkg;

  typedef enum logic [2:0] {
    CMD_IDLE  = 3'b000,
    CMD_READ  = 3'b001,
    CMD_WRITE = 3'b010,
    CMD_RDATA = 3'b011,
    CMD_WDATA = 3'b100,
    CMD_ERR   = 3'b111
  } cmd_t;

  typedef enum logic [1:0] {
    LEN_1 = 2'd0,
    LEN_2 = 2'd1,
    LEN_4 = 2'd2,
    LEN_8 = 2'd3
  } len_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_RWAIT,
    ST_RDATA,
    ST_ERR
  } state_t;

  localparam int MAX_BEATS = 8;

  function automatic logic [3:0] len2beats(input len_t len);
    return 4'd1 << len;
  endfunction

endpackage

// File: rtl/bus_mem_sp_ram.sv
// rtl/bus_mem_sp_ram.sv - single-port word RAM, synchronous read with one cycle latency
module bus_mem_sp_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/bus_mem_target.sv
// rtl/bus_mem_target.sv - request-bus memory target: burst writes and latency-controlled burst reads
module bus_mem_target
  import bus_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          RD_LAT    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        selin,
  input  logic [2:0]  cmdin,
  input  logic [1:0]  lenin,
  input  logic [31:0] addrdatain,
  output logic        ackout,
  output logic        busy,
  output logic [2:0]  cmdout,
  output logic [31:0] addrdataout
);

  localparam int IW = $clog2(MEM_WORDS);

  state_t         state_q, state_d;
  logic [IW-1:0]  index_q, index_d;
  logic [3:0]     count_q, count_d;
  logic [3:0]     wait_q, wait_d;
  logic           ack_q, ack_d;
  logic           busy_q;
  cmd_t           cmd_q, cmd_d;
  logic [31:0]    data_q, data_d;

  logic [IW-1:0]  ram_addr;
  logic           ram_we;
  logic [31:0]    ram_rdata;

  logic [32:0]    req_off;
  logic [31:0]    req_word;
  logic [3:0]     req_beats;
  logic [32:0]    req_end;
  logic           req_ok;
  logic           req_rw;

  // Offset borrow flags addresses below the window; no wrap past the top.
  assign req_off   = {1'b0, addrdatain} - {1'b0, BASE_ADDR};
  assign req_word  = req_off[31:0] >> 2;
  assign req_beats = len2beats(len_t'(lenin));
  assign req_end   = {1'b0, req_word} + 33'(req_beats);
  assign req_ok    = (addrdatain[1:0] == 2'b00) && !req_off[32] &&
                     (req_end <= 33'(MEM_WORDS));
  assign req_rw    = (cmdin == CMD_READ) || (cmdin == CMD_WRITE);

  bus_mem_sp_ram #(
    .DEPTH (MEM_WORDS),
    .AW    (IW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (addrdatain),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    count_d  = count_q;
    wait_d   = wait_q;
    ack_d    = 1'b0;
    cmd_d    = CMD_IDLE;
    data_d   = '0;
    ram_addr = index_q;
    ram_we   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Prefetch the first read word while the address is still on the bus.
        ram_addr = req_word[IW-1:0];
        if (selin && req_rw) begin
          if (req_ok) begin
            ack_d   = 1'b1;
            index_d = req_word[IW-1:0];
            count_d = req_beats;
            wait_d  = 4'(RD_LAT);
            state_d = (cmdin == CMD_WRITE) ? ST_WDATA : ST_RWAIT;
          end else begin
            cmd_d   = CMD_ERR;
            state_d = ST_ERR;
          end
        end
      end

      ST_WDATA: begin
        if (selin) begin
          if (cmdin == CMD_WDATA) begin
            ram_we  = 1'b1;
            index_d = index_q + IW'(1);
            count_d = count_q - 4'd1;
            if (count_q == 4'd1) state_d = ST_IDLE;
          end else begin
            cmd_d   = CMD_ERR;
            state_d = ST_ERR;
          end
        end
      end

      ST_RWAIT: begin
        if (wait_q == 4'd0) begin
          ram_addr = index_q + IW'(1);
          cmd_d    = CMD_RDATA;
          data_d   = ram_rdata;
          index_d  = index_q + IW'(1);
          count_d  = count_q - 4'd1;
          state_d  = ST_RDATA;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      ST_RDATA: begin
        // ram_rdata already holds mem[index_q]; fetch the following word now.
        if (count_q != 4'd0) begin
          ram_addr = index_q + IW'(1);
          cmd_d    = CMD_RDATA;
          data_d   = ram_rdata;
          index_d  = index_q + IW'(1);
          count_d  = count_q - 4'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      count_q <= '0;
      wait_q  <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      cmd_q   <= CMD_IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      count_q <= count_d;
      wait_q  <= wait_d;
      ack_q   <= ack_d;
      busy_q  <= (state_d != ST_IDLE);
      cmd_q   <= cmd_d;
      data_q  <= data_d;
    end
  end

  assign ackout      = ack_q;
  assign busy        = busy_q;
  assign cmdout      = cmd_q;
  assign addrdataout = data_q;

endmodule

// File: tb/tb_bus_mem_target.sv
// tb/tb_bus_mem_target.sv - directed bench for bus_mem_target at read latencies 0, 2 and 3
module tb_bus_mem_target;
  import bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        selin = 1'b0;
  logic [2:0]  cmdin = 3'b000;
  logic [1:0]  lenin = 2'b00;
  logic [31:0] addrdatain = 32'h0;

  logic ack0, busy0, ack2, busy2, ack3, busy3;
  logic [2:0]  cmd0, cmd2, cmd3;
  logic [31:0] data0, data2, data3;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] model [0:1023];

  always #5 clk = ~clk;

  bus_mem_target #(.RD_LAT(2)) dut (
    .clk(clk), .reset(reset), .selin(selin), .cmdin(cmdin), .lenin(lenin),
    .addrdatain(addrdatain), .ackout(ack2), .busy(busy2), .cmdout(cmd2), .addrdataout(data2));
  bus_mem_target #(.RD_LAT(0)) dut_l0 (
    .clk(clk), .reset(reset), .selin(selin), .cmdin(cmdin), .lenin(lenin),
    .addrdatain(addrdatain), .ackout(ack0), .busy(busy0), .cmdout(cmd0), .addrdataout(data0));
  bus_mem_target #(.RD_LAT(3)) dut_l3 (
    .clk(clk), .reset(reset), .selin(selin), .cmdin(cmdin), .lenin(lenin),
    .addrdatain(addrdatain), .ackout(ack3), .busy(busy3), .cmdout(cmd3), .addrdataout(data3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag, input logic ack, input logic bsy,
                          input logic [2:0] cmd, input logic [31:0] data);
    chk({tag, " ackout"}, {31'b0, ack}, 32'h0);
    chk({tag, " busy"}, {31'b0, bsy}, 32'h0);
    chk({tag, " cmdout"}, {29'b0, cmd}, 32'h0);
    chk({tag, " addrdataout"}, data, 32'h0);
  endtask

  // Sample k is taken just after the k-th edge following the address-sampling edge.
  task automatic chk_cycle(input string tag, input int lat, input int k, input int beats,
                           input int idx0, input logic ack, input logic bsy,
                           input logic [2:0] cmd, input logic [31:0] data);
    int first;
    bit in_burst;
    logic [31:0] exp_d;
    first = 2 + lat;
    in_burst = (k >= first) && (k < first + beats);
    exp_d = in_burst ? model[idx0 + k - first] : 32'h0;
    chk($sformatf("%s k%0d ackout", tag, k), {31'b0, ack}, {31'b0, (k == 1)});
    chk($sformatf("%s k%0d busy", tag, k), {31'b0, bsy}, {31'b0, (k <= first + beats - 1)});
    chk($sformatf("%s k%0d cmdout", tag, k), {29'b0, cmd},
        in_burst ? 32'(CMD_RDATA) : 32'(CMD_IDLE));
    chk($sformatf("%s k%0d addrdataout", tag, k), data, exp_d);
  endtask

  task automatic check_read(input string tag, input logic [31:0] addr, input logic [1:0] len);
    int beats;
    int idx0;
    beats = 1 << len;
    idx0 = int'(addr >> 2);
    selin = 1'b1; cmdin = CMD_READ; lenin = len; addrdatain = addr;
    tick();
    selin = 1'b0; cmdin = CMD_IDLE; addrdatain = 32'h0;
    for (int k = 1; k <= beats + 6; k++) begin
      if (k > 1) tick();
      chk_cycle({tag, "/lat0"}, 0, k, beats, idx0, ack0, busy0, cmd0, data0);
      chk_cycle({tag, "/lat2"}, 2, k, beats, idx0, ack2, busy2, cmd2, data2);
      chk_cycle({tag, "/lat3"}, 3, k, beats, idx0, ack3, busy3, cmd3, data3);
    end
  endtask

  task automatic wr_burst(input string tag, input logic [31:0] addr, input logic [1:0] len,
                          input logic [31:0] d0);
    int beats;
    beats = 1 << len;
    selin = 1'b1; cmdin = CMD_WRITE; lenin = len; addrdatain = addr;
    tick();
    chk({tag, " ackout"}, {31'b0, ack2}, 32'h1);
    for (int i = 0; i < beats; i++) begin
      cmdin = CMD_WDATA;
      addrdatain = d0 + 32'(i);
      model[int'(addr >> 2) + i] = d0 + 32'(i);
      tick();
      chk($sformatf("%s beat%0d busy", tag, i), {31'b0, busy2}, {31'b0, (i < beats - 1)});
    end
    selin = 1'b0; cmdin = CMD_IDLE; addrdatain = 32'h0;
    tick();
  endtask

  task automatic err_req(input string tag, input logic [2:0] cmd, input logic [1:0] len,
                         input logic [31:0] addr);
    selin = 1'b1; cmdin = cmd; lenin = len; addrdatain = addr;
    tick();
    chk({tag, " ackout"}, {31'b0, ack2}, 32'h0);
    chk({tag, " cmdout lat2"}, {29'b0, cmd2}, 32'(CMD_ERR));
    chk({tag, " cmdout lat0"}, {29'b0, cmd0}, 32'(CMD_ERR));
    chk({tag, " busy"}, {31'b0, busy2}, 32'h1);
    cmdin = CMD_WDATA; addrdatain = 32'h1234_5678;
    tick();
    chk({tag, " cmdout after"}, {29'b0, cmd2}, 32'(CMD_IDLE));
    chk({tag, " busy after"}, {31'b0, busy2}, 32'h0);
    tick();
    chk({tag, " ackout stray beat"}, {31'b0, ack2}, 32'h0);
    selin = 1'b0; cmdin = CMD_IDLE; addrdatain = 32'h0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    tick();
    tick();
    chk_zero("reset lat2", ack2, busy2, cmd2, data2);
    chk_zero("reset lat0", ack0, busy0, cmd0, data0);
    reset = 1'b0;
    tick();
    chk_zero("post-reset", ack2, busy2, cmd2, data2);

    wr_burst("wr4", 32'h40, 2'd2, 32'hA0);
    check_read("rd4", 32'h40, 2'd2);

    wr_burst("wr1", 32'h0, 2'd0, 32'hDEAD_BEEF);
    check_read("rd1", 32'h0, 2'd0);

    wr_burst("wr_top", 32'hFF0, 2'd2, 32'h5500_0000);
    check_read("rd_top", 32'hFF0, 2'd2);
    err_req("rd_oob", CMD_READ, 2'd3, 32'hFF0);
    err_req("wr_unal", CMD_WRITE, 2'd0, 32'h2);
    check_read("rd1_after_err", 32'h0, 2'd0);

    selin = 1'b1; cmdin = CMD_WRITE; lenin = 2'd1; addrdatain = 32'h100;
    tick();
    chk("stall ackout", {31'b0, ack2}, 32'h1);
    cmdin = CMD_WDATA; addrdatain = 32'hB0B0_0000; model[64] = 32'hB0B0_0000;
    tick();
    chk("stall beat0 busy", {31'b0, busy2}, 32'h1);
    selin = 1'b0; cmdin = CMD_IDLE; addrdatain = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall gap%0d busy", i), {31'b0, busy2}, 32'h1);
    end
    selin = 1'b1; cmdin = CMD_WDATA; addrdatain = 32'hB0B0_0001; model[65] = 32'hB0B0_0001;
    tick();
    chk("stall beat1 busy", {31'b0, busy2}, 32'h0);
    selin = 1'b0; cmdin = CMD_IDLE; addrdatain = 32'h0;
    tick();
    check_read("rd_stall", 32'h100, 2'd1);

    wr_burst("wr8", 32'h40, 2'd3, 32'hC0);
    check_read("rd8", 32'h40, 2'd3);

    selin = 1'b1; cmdin = CMD_READ; lenin = 2'd3; addrdatain = 32'h40;
    tick();
    selin = 1'b0; cmdin = CMD_IDLE; addrdatain = 32'h0;
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) tick();
      chk_cycle("rd8_overlap", 2, k, 8, 16, ack2, busy2, cmd2, data2);
      if (k == 5) begin
        selin = 1'b1; cmdin = CMD_READ; lenin = 2'd0; addrdatain = 32'h0;
      end else if (k == 6) begin
        selin = 1'b0; cmdin = CMD_IDLE;
      end
    end
    reset = 1'b1;
    tick();
    chk_zero("midburst reset lat2", ack2, busy2, cmd2, data2);
    chk_zero("midburst reset lat0", ack0, busy0, cmd0, data0);
    chk_zero("midburst reset lat3", ack3, busy3, cmd3, data3);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_zero($sformatf("after reset %0d", i), ack2, busy2, cmd2, data2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_mem_target.md
Name: bus_mem_target

Overview:
- Bus target (responder) end of the video/system request bus that the frame fetch initiator drives.
- Accepts address-phase READ/WRITE commands with burst length, absorbs write data beats, and returns read data beats from a local word-addressed memory.
- Sits behind the bus arbiter as a frame/line store feeding the video pipeline.

Parameters:
- MEM_WORDS, 1024: memory depth in 32-bit words (power of two).
- BASE_ADDR, 32'h0000_0000: byte base address of this target's window.
- RD_LAT, 2: idle cycles between ackout and the first read data beat (0..15).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- selin  in  1  target selected this cycle; cmdin/lenin/addrdatain valid
- cmdin  in  3  command (package encodings)
- lenin  in  2  burst length code, sampled in address phase
- addrdatain  in  32  byte address (address phase) or write data (data phase)
- ackout  out  1  one-cycle pulse: address phase accepted
- busy  out  1  high in any state other than IDLE
- cmdout  out  3  CMD_IDLE, CMD_RDATA or CMD_ERR
- addrdataout  out  32  read data beat, 0 when cmdout is not CMD_RDATA

Behaviour:
- Reset: state IDLE; ackout=0, busy=0, cmdout=CMD_IDLE, addrdataout=0; counters cleared; memory contents preserved. All outputs are registered.
- Burst beats: lenin 0/1/2/3 gives 1/2/4/8 beats. Word index = (addr-BASE_ADDR)>>2, incremented by 1 per beat.
- Range check, performed in IDLE: the request is rejected if addr[1:0]!=0, addr<BASE_ADDR, or index+beats>MEM_WORDS. There is no wrap-around.
- FSM states: IDLE, WDATA, RWAIT, RDATA, ERR.
- IDLE, selin and READ or WRITE valid: latch index and beat count; ackout=1 next cycle; go to WDATA (for WRITE) or RWAIT (for READ).
- IDLE, selin and READ or WRITE rejected: no ackout; go to ERR.
- IDLE, selin with any other command: ignored.
- WDATA, selin and cmdin==CMD_WDATA: mem[index]<=addrdatain; index++; count--. After the last beat, go to IDLE.
- WDATA, !selin: stall and hold state indefinitely.
- WDATA, selin with any other command: abort; beats already written stay written; go to ERR.
- RWAIT: count RD_LAT cycles, then go to RDATA.
- RDATA: one beat per consecutive cycle, with no backpressure: cmdout=CMD_RDATA, addrdataout=mem[index]. After the last beat, return to IDLE with cmdout=CMD_IDLE.
- ERR: cmdout=CMD_ERR for exactly one cycle, then IDLE.
- Read timing: address sampled at edge T gives ackout high in cycle T+1 and the first RDATA beat at cycle T+2+RD_LAT. For RD_LAT=2 that is T+4, with the last beat of an 8-beat burst at T+11.
- Write-data timing: the first data beat may arrive in cycle T+1, concurrent with ackout.
- Back-to-back: a new address is accepted on the same edge the FSM re-enters IDLE only if it arrives the cycle after, i.e. there is one idle cycle between bursts. READ/WRITE arriving while busy=1 is ignored and produces no ackout.
- Reset mid-burst: takes effect on the next edge. The burst is dropped, outputs go to reset values, and no partial data or ERR is emitted.

Decomposition:
- Shared package bus_pkg:
  - cmd_t enum: CMD_IDLE=3'b000, CMD_READ=3'b001, CMD_WRITE=3'b010, CMD_RDATA=3'b011, CMD_WDATA=3'b100, CMD_ERR=3'b111.
  - len_t plus function len2beats.
  - state_t for this FSM.
  - Shared by all initiators and targets.
- One sub-module, bus_mem_sp_ram: single-port synchronous-read RAM with 1-cycle read. The FSM prefetches so that RDATA beats remain contiguous.

Test Plan:
- WRITE lenin=2 at 32'h40, data beats A0..A3 in consecutive cycles, then READ lenin=2 at 32'h40. Expect one ackout pulse per request and RDATA A0,A1,A2,A3 in 4 consecutive cycles starting T+4.
- READ lenin=0 at 32'h0 after writing 32'hDEADBEEF, with RD_LAT swept 0 and 3. Expect the single beat exactly at T+2 and T+5, with cmdout=CMD_IDLE before and after.
- READ lenin=3 at byte address (MEM_WORDS-4)*4, and separately WRITE at 32'h2. Expect no ackout, cmdout=CMD_ERR for one cycle, busy low afterward, and memory unchanged.
- WRITE lenin=1 with selin low for 3 cycles between beats. Expect both words stored, and busy high throughout until the second beat.
- A second READ asserted during RDATA, and a reset asserted mid 8-beat read. Expect the second READ ignored with no ackout, and after reset all outputs 0 next cycle with no further beats.
